pbit_histogram: RTL and testbench

Synthesizable on-chip replacement for bench-side p-bit state histogramming. The block samples a p-bit network output vector once per network sweep, optionally bit-reverses it, and keeps a saturating occurrence count for every one of the 2^N_PBITS states in a RAM. Firmware or a bench reads the counts back after a stop. It sits beside the p-bit top level and taps its output bus. It generalises fixed-width, fixed-divider sampling to a parametrised width, interval, counter width, bit order and burn-in.

---
 rtl/pbit_hist_pkg.sv | 23 ++
 rtl/pbit_hist_ram.sv | 27 ++
 rtl/pbit_histogram.sv | 154 +++++++++++++++
 tb/tb_pbit_histogram.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_hist_pkg.sv
// Shared types for the p-bit state histogrammer: FSM state encoding and a
// width-generic bit-reversal helper used to form RAM addresses.
package pbit_hist_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_BURN,
    ST_RUN,
    ST_DRAIN
  } state_e;

  // Reverses the low 'width' bits of v; bits above 'width' come back as zero.
  function automatic logic [31:0] bit_reverse(input logic [31:0] v, input int width);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = v[width - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/pbit_hist_ram.sv
// Simple dual-port histogram RAM: one write port, one registered read port.
module pbit_hist_ram
  import pbit_hist_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic          CLK,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge CLK) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/pbit_histogram.sv
// Samples a p-bit output vector once per sweep and keeps a saturating
// occurrence count per state in RAM; counts are read back while idle.
module pbit_histogram
  import pbit_hist_pkg::*;
#(
  parameter int N_PBITS         = 8,
  parameter int SAMPLE_INTERVAL = 24,
  parameter int CNT_W           = 16,
  parameter bit REVERSE         = 1'b1,
  parameter int BURN_IN         = 0
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [N_PBITS-1:0] pbit_in,
  input  logic               start,
  input  logic               stop,
  input  logic               clear,
  input  logic               rd_req,
  input  logic [N_PBITS-1:0] rd_addr,
  output logic               rd_valid,
  output logic [CNT_W-1:0]   rd_data,
  output logic               busy,
  output logic [31:0]        sample_count,
  output logic               saturated
);

  localparam int IW = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
  localparam int BW = (BURN_IN > 0) ? $clog2(BURN_IN + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e             state_q;
  logic [N_PBITS-1:0] sweep_q;
  logic [N_PBITS-1:0] addr_q;
  logic [IW-1:0]      int_q;
  logic [BW-1:0]      burn_q;
  logic               s1_q;
  logic               s2_q;
  logic               rd_pend_q;
  logic               rd_valid_q;
  logic [CNT_W-1:0]   rd_data_q;
  logic [31:0]        cnt_q;
  logic               sat_q;

  logic               sampling;
  logic               tick;
  logic               record;
  logic               rd_fire;
  logic [N_PBITS-1:0] sample_addr;
  logic [CNT_W-1:0]   ram_rdata;
  logic [CNT_W-1:0]   inc;
  logic               ram_we;
  logic [N_PBITS-1:0] ram_waddr;
  logic [CNT_W-1:0]   ram_wdata;
  logic               ram_re;
  logic [N_PBITS-1:0] ram_raddr;

  always_comb begin
    sampling    = (state_q == ST_BURN) || (state_q == ST_RUN);
    tick        = sampling && (int_q == IW'(SAMPLE_INTERVAL - 1));
    record      = tick && !stop && (state_q == ST_RUN);
    rd_fire     = (state_q == ST_IDLE) && rd_req;
    sample_addr = REVERSE ? N_PBITS'(bit_reverse(32'(pbit_in), N_PBITS)) : pbit_in;
    inc         = (ram_rdata == CNT_MAX) ? CNT_MAX : ram_rdata + CNT_W'(1);
    // The shared read port belongs to readout only while idle.
    ram_re      = rd_fire || s1_q;
    ram_raddr   = (state_q == ST_IDLE) ? rd_addr : addr_q;
    ram_we      = (state_q == ST_CLEAR) || s2_q;
    ram_waddr   = (state_q == ST_CLEAR) ? sweep_q : addr_q;
    ram_wdata   = (state_q == ST_CLEAR) ? '0 : inc;
  end

  pbit_hist_ram #(
    .AW (N_PBITS),
    .DW (CNT_W)
  ) u_ram (
    .CLK     (CLK),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_CLEAR;
      sweep_q    <= '0;
      addr_q     <= '0;
      int_q      <= '0;
      burn_q     <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      s1_q       <= record;
      s2_q       <= s1_q;
      rd_pend_q  <= rd_fire;
      rd_valid_q <= rd_pend_q;
      if (rd_pend_q) rd_data_q <= ram_rdata;
      if (s2_q && (inc == CNT_MAX)) sat_q <= 1'b1;
      if (record) begin
        addr_q <= sample_addr;
        if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
      end
      // Wrapping at the tick also restarts the interval on BURN -> RUN.
      if (sampling) int_q <= tick ? '0 : int_q + IW'(1);
      else          int_q <= '0;

      case (state_q)
        ST_CLEAR: begin
          cnt_q   <= '0;
          sat_q   <= 1'b0;
          sweep_q <= sweep_q + N_PBITS'(1);
          if (sweep_q == '1) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (clear) begin
            sweep_q <= '0;
            state_q <= ST_CLEAR;
          end else if (start) begin
            burn_q  <= '0;
            state_q <= (BURN_IN > 0) ? ST_BURN : ST_RUN;
          end
        end
        ST_BURN: begin
          if (stop) state_q <= ST_DRAIN;
          else if (tick) begin
            if (burn_q == BW'(BURN_IN - 1)) state_q <= ST_RUN;
            else burn_q <= burn_q + BW'(1);
          end
        end
        ST_RUN: begin
          if (stop) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!s1_q && !s2_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_CLEAR;
      endcase
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_data_q;
  assign sample_count = cnt_q;
  assign saturated    = sat_q;

endmodule

// File: tb/tb_pbit_histogram.sv
// Directed bench: four histogrammers with different parameters share one
// stimulus stream so each feature is visible on the matching instance.
module tb_pbit_histogram;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [7:0]  pbitIn;
  logic        start, stop, clear, rdReq;
  logic [7:0]  rdAddr;

  logic        rdValid0, rdValid1, rdValid2, rdValid3;
  logic [15:0] rdData0, rdData1, rdData2;
  logic [3:0]  rdData3;
  logic        busy0, busy1, busy2, busy3;
  logic [31:0] sampleCount0, sampleCount1, sampleCount2, sampleCount3;
  logic        saturated0, saturated1, saturated2, saturated3;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pbit_histogram #(.REVERSE(1'b1)) dut0 (
    .CLK(CLK), .RST_N(RST_N), .pbit_in(pbitIn), .start(start), .stop(stop), .clear(clear),
    .rd_req(rdReq), .rd_addr(rdAddr), .rd_valid(rdValid0), .rd_data(rdData0), .busy(busy0),
    .sample_count(sampleCount0), .saturated(saturated0));

  pbit_histogram #(.REVERSE(1'b0)) dut1 (
    .CLK(CLK), .RST_N(RST_N), .pbit_in(pbitIn), .start(start), .stop(stop), .clear(clear),
    .rd_req(rdReq), .rd_addr(rdAddr), .rd_valid(rdValid1), .rd_data(rdData1), .busy(busy1),
    .sample_count(sampleCount1), .saturated(saturated1));

  pbit_histogram #(.BURN_IN(4)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .pbit_in(pbitIn), .start(start), .stop(stop), .clear(clear),
    .rd_req(rdReq), .rd_addr(rdAddr), .rd_valid(rdValid2), .rd_data(rdData2), .busy(busy2),
    .sample_count(sampleCount2), .saturated(saturated2));

  pbit_histogram #(.CNT_W(4)) dut3 (
    .CLK(CLK), .RST_N(RST_N), .pbit_in(pbitIn), .start(start), .stop(stop), .clear(clear),
    .rd_req(rdReq), .rd_addr(rdAddr), .rd_valid(rdValid3), .rd_data(rdData3), .busy(busy3),
    .sample_count(sampleCount3), .saturated(saturated3));

  task automatic waitIdle(output int cycles);
    cycles = 0;
    while (busy0 && cycles < 2000) begin
      @(posedge CLK);
      @(negedge CLK);
      cycles++;
    end
  endtask

  // Issues one read on all instances; reports whether any rd_valid came early
  // (T+1) and whether all were valid at T+2.
  task automatic readAll(input logic [7:0] a, output logic [15:0] d0, output logic [15:0] d1,
                         output logic [15:0] d2, output logic [3:0] d3,
                         output logic early, output logic onTime);
    @(negedge CLK);
    rdAddr = a;
    rdReq  = 1'b1;
    @(negedge CLK);
    rdReq  = 1'b0;
    early  = rdValid0 | rdValid1 | rdValid2 | rdValid3;
    @(negedge CLK);
    onTime = rdValid0 & rdValid1 & rdValid2 & rdValid3;
    d0 = rdData0; d1 = rdData1; d2 = rdData2; d3 = rdData3;
  endtask

  // Start pulse, then stop in cycle stopAt after entry (cycle 0 follows the
  // start edge); rdReq pulses in cycle rdAt. Counts any rd_valid seen.
  task automatic applyStimulus(input int stopAt, input int rdAt, output int badValid);
    badValid = 0;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 0; c <= stopAt + 3; c++) begin
      rdReq = (c == rdAt);
      stop  = (c == stopAt);
      if (rdValid0 | rdValid1 | rdValid2 | rdValid3) badValid++;
      @(negedge CLK);
    end
    rdReq = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic [15:0] d0, d1, d2;
    logic [3:0] d3;
    logic early, onTime;
    logic [7:0] addrs [3];
    addrs[0] = 8'h00; addrs[1] = 8'h01; addrs[2] = 8'hFF;
    RST_N = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({busy0, busy1, busy2, busy3} !== 4'hF) begin
      errors++; $display("[TB] FAIL reset_busy: got %b expected 1111", {busy0, busy1, busy2, busy3});
    end
    checks++;
    if ({rdValid0, rdData0, sampleCount0, saturated0} !== 50'd0) begin
      errors++; $display("[TB] FAIL reset_outputs: rd_valid %0d rd_data %0d sample_count %0d saturated %0d expected all 0",
                         rdValid0, rdData0, sampleCount0, saturated0);
    end
    RST_N = 1'b1;
    waitIdle(n);
    checks++;
    if (n !== 256) begin
      errors++; $display("[TB] FAIL clear_len_after_reset: got %0d cycles expected 256", n);
    end
    checks++;
    if ({busy1, busy2, busy3} !== 3'b000) begin
      errors++; $display("[TB] FAIL idle_after_clear: busy %b expected 000", {busy1, busy2, busy3});
    end
    foreach (addrs[i]) begin
      readAll(addrs[i], d0, d1, d2, d3, early, onTime);
      checks++;
      if (early !== 1'b0 || onTime !== 1'b1) begin
        errors++; $display("[TB] FAIL read_latency_%0h: early %0d on_time %0d expected 0 1", addrs[i], early, onTime);
      end
      checks++;
      if ({d0, d1, d2, d3} !== 52'd0) begin
        errors++; $display("[TB] FAIL read_zero_%0h: got %0d %0d %0d %0d expected 0", addrs[i], d0, d1, d2, d3);
      end
    end
    checks++;
    if (sampleCount0 !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_sample_count: got %0d expected 0", sampleCount0);
    end
  endtask

  // Ten ticks at c=23,47..239; stop lands on the 11th tick at c=263.
  task automatic test_sampling();
    int bad, n;
    logic [15:0] d0, d1, d2;
    logic [3:0] d3;
    logic early, onTime;
    pbitIn = 8'b0000_0001;
    rdAddr = 8'h80;
    applyStimulus(263, 100, bad);
    checks++;
    if (bad !== 0) begin
      errors++; $display("[TB] FAIL rd_req_in_run: got %0d rd_valid cycles expected 0", bad);
    end
    waitIdle(n);
    checks++;
    if (n !== 0) begin
      errors++; $display("[TB] FAIL drain_to_idle: got %0d extra cycles expected 0", n);
    end
    readAll(8'h80, d0, d1, d2, d3, early, onTime);
    checks++;
    if (d0 !== 16'd10) begin
      errors++; $display("[TB] FAIL rev_count_80: got %0d expected 10", d0);
    end
    checks++;
    if (d1 !== 16'd0) begin
      errors++; $display("[TB] FAIL norev_count_80: got %0d expected 0", d1);
    end
    checks++;
    if (d2 !== 16'd6) begin
      errors++; $display("[TB] FAIL burnin_count: got %0d expected 6", d2);
    end
    checks++;
    if (d3 !== 4'd10) begin
      errors++; $display("[TB] FAIL narrow_count: got %0d expected 10", d3);
    end
    readAll(8'h01, d0, d1, d2, d3, early, onTime);
    checks++;
    if (d0 !== 16'd0) begin
      errors++; $display("[TB] FAIL rev_count_01: got %0d expected 0", d0);
    end
    checks++;
    if (d1 !== 16'd10) begin
      errors++; $display("[TB] FAIL norev_count_01: got %0d expected 10", d1);
    end
    checks++;
    if ({sampleCount0, sampleCount1, sampleCount2, sampleCount3} !== {32'd10, 32'd10, 32'd6, 32'd10}) begin
      errors++; $display("[TB] FAIL sample_counts: got %0d %0d %0d %0d expected 10 10 6 10",
                         sampleCount0, sampleCount1, sampleCount2, sampleCount3);
    end
    checks++;
    if ({saturated0, saturated3} !== 2'b00) begin
      errors++; $display("[TB] FAIL saturated_early: got %b expected 00", {saturated0, saturated3});
    end
  endtask

  task automatic test_saturation();
    int bad, n;
    logic [15:0] d0, d1, d2;
    logic [3:0] d3;
    logic early, onTime;
    applyStimulus(263, -1, bad);
    readAll(8'h80, d0, d1, d2, d3, early, onTime);
    checks++;
    if ({d0, d2} !== {16'd20, 16'd12}) begin
      errors++; $display("[TB] FAIL persist_counts: got %0d %0d expected 20 12", d0, d2);
    end
    checks++;
    if (d3 !== 4'd15) begin
      errors++; $display("[TB] FAIL sat_count: got %0d expected 15", d3);
    end
    checks++;
    if ({saturated3, saturated0} !== 2'b10) begin
      errors++; $display("[TB] FAIL sat_flag: got %b expected 10", {saturated3, saturated0});
    end
    checks++;
    if (sampleCount3 !== 32'd20) begin
      errors++; $display("[TB] FAIL sat_sample_count: got %0d expected 20", sampleCount3);
    end
    @(negedge CLK);
    clear = 1'b1;
    @(negedge CLK);
    clear = 1'b0;
    waitIdle(n);
    checks++;
    if (n !== 256) begin
      errors++; $display("[TB] FAIL clear_len: got %0d cycles expected 256", n);
    end
    readAll(8'h80, d0, d1, d2, d3, early, onTime);
    checks++;
    if ({d0, d3} !== 20'd0) begin
      errors++; $display("[TB] FAIL cleared_counts: got %0d %0d expected 0 0", d0, d3);
    end
    checks++;
    if ({saturated3, sampleCount3} !== 33'd0) begin
      errors++; $display("[TB] FAIL cleared_status: saturated %0d sample_count %0d expected 0 0", saturated3, sampleCount3);
    end
  endtask

  task automatic test_start_clear();
    int n;
    @(negedge CLK);
    start = 1'b1;
    clear = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    clear = 1'b0;
    waitIdle(n);
    checks++;
    if (n !== 256) begin
      errors++; $display("[TB] FAIL start_clear_len: got %0d cycles expected 256", n);
    end
    repeat (60) @(negedge CLK);
    checks++;
    if ({busy0, sampleCount0} !== 33'd0) begin
      errors++; $display("[TB] FAIL start_clear_nosample: busy %0d sample_count %0d expected 0 0", busy0, sampleCount0);
    end
  endtask

  task automatic test_reset_midrun();
    int n;
    logic [15:0] d0, d1, d2;
    logic [3:0] d3;
    logic early, onTime;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (60) @(negedge CLK);
    checks++;
    if (sampleCount0 !== 32'd2) begin
      errors++; $display("[TB] FAIL midrun_count: got %0d expected 2", sampleCount0);
    end
    RST_N = 1'b0;
    @(negedge CLK);
    checks++;
    if ({busy0, sampleCount0} !== {1'b1, 32'd0}) begin
      errors++; $display("[TB] FAIL midrun_reset: busy %0d sample_count %0d expected 1 0", busy0, sampleCount0);
    end
    RST_N = 1'b1;
    waitIdle(n);
    checks++;
    if (n !== 256) begin
      errors++; $display("[TB] FAIL midrun_clear_len: got %0d cycles expected 256", n);
    end
    readAll(8'h80, d0, d1, d2, d3, early, onTime);
    checks++;
    if ({d0, d2, d3} !== 36'd0) begin
      errors++; $display("[TB] FAIL midrun_cleared: got %0d %0d %0d expected 0", d0, d2, d3);
    end
  endtask

  initial begin
    RST_N  = 1'b0;
    pbitIn = 8'h00;
    start  = 1'b0;
    stop   = 1'b0;
    clear  = 1'b0;
    rdReq  = 1'b0;
    rdAddr = 8'h00;
    test_reset();
    test_sampling();
    test_saturation();
    test_start_clear();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
